intc_nmi_arb: RTL and testbench

INTC_NMI_ARB -- requirements
Module: intc_nmi_arb

---
 rtl/intc_nmi_arb.sv | 111 +++++++++++
 tb/tb_intc_nmi_arb.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/intc_nmi_arb.sv
// Round-robin NMI arbiter: grants one pending source at a time and pulses its capture clear.
// Optional post-clear holdoff window enabled by defining INTC_NMI_HOLDOFF_EN.
module intc_nmi_arb #(
  parameter int CPU_NUM = 4,
  parameter int HOLDOFF = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CPU_NUM-1:0]         nmi_pend_i,
  input  logic                       nmi_ack_i,
  output logic                       nmi_req_o,
  output logic [$clog2(CPU_NUM)-1:0] nmi_id_o,
  output logic [CPU_NUM-1:0]         nmi_clr_o,
  output logic                       busy_o
);
  localparam int IW = $clog2(CPU_NUM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CLR
`ifdef INTC_NMI_HOLDOFF_EN
    , S_HOLD
`endif
  } state_t;

  state_t             r_state;
  logic               r_req;
  logic [IW-1:0]      r_id;
  logic [IW-1:0]      r_last;
  logic [CPU_NUM-1:0] r_clr;
`ifdef INTC_NMI_HOLDOFF_EN
  logic [7:0]         r_hcnt;
`endif

  logic               w_found;
  logic [IW-1:0]      w_win;
  logic [CPU_NUM-1:0] w_onehot;

  // Search starts one past the last served source so every source gets a turn.
  always_comb begin : p_rr
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < CPU_NUM; k++) begin
      idx = (int'(r_last) + 1 + k) % CPU_NUM;
      if (!w_found && nmi_pend_i[idx]) begin
        w_found = 1'b1;
        w_win   = IW'(idx);
      end
    end
  end

  assign w_onehot = CPU_NUM'(1) << r_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_id    <= '0;
      r_last  <= IW'(CPU_NUM - 1);
      r_clr   <= '0;
`ifdef INTC_NMI_HOLDOFF_EN
      r_hcnt  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id    <= w_win;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        // Grant is held regardless of pending: an NMI cannot be withdrawn.
        S_REQ: begin
          if (nmi_ack_i) begin
            r_req   <= 1'b0;
            r_clr   <= w_onehot;
            r_last  <= r_id;
            r_state <= S_CLR;
          end
        end
        // Arbitration is skipped here so a stale pending bit is never re-granted.
        S_CLR: begin
          r_clr <= '0;
`ifdef INTC_NMI_HOLDOFF_EN
          r_hcnt  <= 8'(HOLDOFF);
          r_state <= S_HOLD;
`else
          r_state <= S_IDLE;
`endif
        end
`ifdef INTC_NMI_HOLDOFF_EN
        S_HOLD: begin
          if (r_hcnt <= 8'd1) r_state <= S_IDLE;
          else                r_hcnt  <= r_hcnt - 8'd1;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign nmi_req_o = r_req;
  assign nmi_id_o  = r_id;
  assign nmi_clr_o = r_clr;
  assign busy_o    = (r_state != S_IDLE);

endmodule

// File: tb/tb_intc_nmi_arb.sv
// Directed table-driven bench for intc_nmi_arb (CPU_NUM=4, HOLDOFF=8), plus an async-reset sequence.
module tb_intc_nmi_arb;
`ifdef INTC_NMI_HOLDOFF_EN
  localparam int HOLD_CYC = 8;
`else
  localparam int HOLD_CYC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pend;
  logic       ack;
  logic       req;
  logic [1:0] id;
  logic [3:0] clr;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  intc_nmi_arb #(.CPU_NUM(4), .HOLDOFF(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nmi_pend_i (pend),
    .nmi_ack_i  (ack),
    .nmi_req_o  (req),
    .nmi_id_o   (id),
    .nmi_clr_o  (clr),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Inputs applied before an edge; expected outputs sampled just after it.
  typedef struct {
    logic       rst_n;
    logic [3:0] pend;
    logic       ack;
    logic       req;
    logic [1:0] id;
    logic [3:0] clr;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rs, logic [3:0] p, logic a,
                              logic rq, logic [1:0] i, logic [3:0] c, logic b);
    vec_t v;
    v.rst_n = rs; v.pend = p; v.ack = a;
    v.req = rq; v.id = i; v.clr = c; v.busy = b;
    tbl.push_back(v);
  endfunction

  // One grant/ack/clear transaction; the trailing row is the edge that lands back in IDLE.
  function automatic void txn(logic [3:0] pg, logic [3:0] pa, logic [1:0] i,
                              int waits, logic ack_post);
    logic [3:0] oh;
    oh = 4'(1) << i;
    add(1'b1, pg, 1'b0, 1'b1, i, 4'b0000, 1'b1);
    for (int w = 0; w < waits; w++) add(1'b1, pa, 1'b0, 1'b1, i, 4'b0000, 1'b1);
    add(1'b1, pa, 1'b1, 1'b0, i, oh, 1'b1);
    for (int h = 0; h < HOLD_CYC; h++) add(1'b1, pa, ack_post, 1'b0, i, 4'b0000, 1'b1);
    add(1'b1, pa, ack_post, 1'b0, i, 4'b0000, 1'b0);
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; pend = 4'b0000; ack = 1'b0;

    // Single source 2, ack three edges after grant.
    txn(4'b0100, 4'b0100, 2'd2, 2, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    // All sources held: strict rotation with wrap back to 0.
    txn(4'b1111, 4'b1111, 2'd0, 2, 1'b0);
    txn(4'b1111, 4'b1111, 2'd1, 2, 1'b0);
    txn(4'b1111, 4'b1111, 2'd2, 2, 1'b0);
    txn(4'b1111, 4'b1111, 2'd3, 2, 1'b0);
    txn(4'b1111, 4'b1111, 2'd0, 2, 1'b0);
    // Pending withdrawn after grant; acks during CLR/HOLD/IDLE ignored.
    txn(4'b0010, 4'b0000, 2'd1, 2, 1'b1);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    // Back-to-back requests from one source expose the post-clear gap.
    txn(4'b0001, 4'b0001, 2'd0, 1, 1'b0);
    txn(4'b0001, 4'b0001, 2'd0, 1, 1'b0);
    // Two sources alternating through the wrap point.
    txn(4'b1010, 4'b1010, 2'd1, 0, 1'b0);
    txn(4'b1010, 4'b1010, 2'd3, 0, 1'b0);
    txn(4'b1010, 4'b0000, 2'd1, 0, 1'b0);

    @(posedge clk); #1;
    chk("rst_req",  -1, 32'(req),  32'd0);
    chk("rst_id",   -1, 32'(id),   32'd0);
    chk("rst_clr",  -1, 32'(clr),  32'd0);
    chk("rst_busy", -1, 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n; pend = tbl[i].pend; ack = tbl[i].ack;
      @(posedge clk); #1;
      chk("req",  i, 32'(req),  32'(tbl[i].req));
      chk("clr",  i, 32'(clr),  32'(tbl[i].clr));
      chk("busy", i, 32'(busy), 32'(tbl[i].busy));
      if (tbl[i].req || !tbl[i].rst_n) chk("id", i, 32'(id), 32'(tbl[i].id));
    end
    rst_n = 1'b1; ack = 1'b0;

    // Reset in the middle of a grant to source 3.
    pend = 4'b1000;
    @(posedge clk); #1;
    chk("mid_req",  0, 32'(req), 32'd1);
    chk("mid_id",   0, 32'(id),  32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req",  1, 32'(req),  32'd0);
    chk("async_id",   1, 32'(id),   32'd0);
    chk("async_clr",  1, 32'(clr),  32'd0);
    chk("async_busy", 1, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("held_clr", 2, 32'(clr), 32'd0);
    chk("held_req", 2, 32'(req), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rearb_req",  3, 32'(req),  32'd1);
    chk("rearb_id",   3, 32'(id),   32'd3);
    chk("rearb_clr",  3, 32'(clr),  32'd0);
    chk("rearb_busy", 3, 32'(busy), 32'd1);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0; pend = 4'b0000;
    chk("rearb_ack_clr", 4, 32'(clr), 32'b1000);
    chk("rearb_ack_req", 4, 32'(req), 32'd0);
    @(posedge clk); #1;
    chk("rearb_clr_once", 5, 32'(clr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
